// File: rtl/mips_datapath.sv
// Multicycle MIPS datapath: PC, IR, Data, A, B, ALUOut, 32x32 register file and ALU.
// All sequencing comes from the external control_bus; memory is external.
module mips_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic [14:0] control_bus,
  output logic [5:0]  op,
  output logic [5:0]  func,
  output logic        zero,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  logic       iord, memwrite, irwrite, pcen, alusrca, regwrite, regdst, memtoreg;
  logic [1:0] pcsrc, alusrcb;
  logic [2:0] alucontrol;

  assign {iord, memwrite, irwrite, pcen, alusrca, regwrite, regdst, memtoreg,
          pcsrc, alusrcb, alucontrol} = control_bus;

  logic [31:0] pc, instr, data, a, b, aluout;
  logic [31:0] rf [0:31];

  logic [31:0] rd1, rd2, signimm, srca, srcb, aluresult, pcnext, wd;
  logic [4:0]  wa;

  assign op        = instr[31:26];
  assign func      = instr[5:0];
  assign mem_addr  = iord ? aluout : pc;
  assign mem_wdata = b;
  assign mem_we    = memwrite;

  // $0 is forced to zero on read so a stray write can never leak out
  assign rd1 = (instr[25:21] == 5'd0) ? '0 : rf[instr[25:21]];
  assign rd2 = (instr[20:16] == 5'd0) ? '0 : rf[instr[20:16]];

  assign signimm = {{16{instr[15]}}, instr[15:0]};
  assign srca    = alusrca ? a : pc;

  always_comb begin
    srcb = b;
    case (alusrcb)
      2'b00: srcb = b;
      2'b01: srcb = 32'd4;
      2'b10: srcb = signimm;
      2'b11: srcb = {signimm[29:0], 2'b00};
      default: srcb = b;
    endcase
  end

  always_comb begin
    aluresult = '0;
    case (alucontrol)
      3'b010:  aluresult = srca + srcb;
      3'b110:  aluresult = srca - srcb;
      3'b000:  aluresult = srca & srcb;
      3'b001:  aluresult = srca | srcb;
      3'b111:  aluresult = {31'd0, $signed(srca) < $signed(srcb)};
      default: aluresult = '0;
    endcase
  end

  assign zero = (aluresult == 32'd0);

  always_comb begin
    pcnext = aluresult;
    case (pcsrc)
      2'b00:   pcnext = aluresult;
      2'b01:   pcnext = aluout;
      2'b10:   pcnext = {pc[31:28], instr[25:0], 2'b00};
      2'b11:   pcnext = aluresult;
      default: pcnext = aluresult;
    endcase
  end

  assign wa = regdst ? instr[15:11] : instr[20:16];
  assign wd = memtoreg ? data : aluout;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= '0;
      instr  <= '0;
      data   <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i[4:0]] <= '0;
    end else begin
      if (irwrite) instr <= mem_rdata;
      if (pcen)    pc    <= pcnext;
      data   <= mem_rdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
      if (regwrite && (wa != 5'd0)) rf[wa] <= wd;
    end
  end

endmodule
